// File: rtl/gin_pkg.sv
// Shared definitions for the conductance pipeline: Q32.32 widths, saturation
// limits and the accumulator FSM encoding.
package gin_pkg;
    localparam int INTEGER_WIDTH     = 32;
    localparam int DATA_WIDTH_FRAC   = 32;
    localparam int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC;
    localparam int NEURON_ID_WIDTH   = 11;
    localparam int SPIKE_COUNT_WIDTH = 10;

    localparam logic signed [DATA_WIDTH-1:0] GIN_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] GIN_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } gin_state_e;
endpackage

// File: rtl/gin_sat_add.sv
// Combinational signed saturating adder; the sum is formed one bit wider so
// overflow shows up as a disagreement between the top two bits.
module gin_sat_add #(
    parameter int DATA_WIDTH = 64
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] sum,
    output logic                         overflow
);
    logic [DATA_WIDTH:0] wide;

    always_comb begin
        wide     = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        overflow = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
        if (!overflow) begin
            sum = wide[DATA_WIDTH-1:0];
        end else if (wide[DATA_WIDTH]) begin
            sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
endmodule

// File: rtl/gin_synaptic_accumulator.sv
// Per-neuron synaptic accumulator: latches the leaked conductance, adds a
// stream of weights with per-beat saturation, then offers the result downstream.
module gin_synaptic_accumulator
    import gin_pkg::*;
#(
    parameter int INTEGER_WIDTH     = gin_pkg::INTEGER_WIDTH,
    parameter int DATA_WIDTH_FRAC   = gin_pkg::DATA_WIDTH_FRAC,
    parameter int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int NEURON_ID_WIDTH   = gin_pkg::NEURON_ID_WIDTH,
    parameter int SPIKE_COUNT_WIDTH = gin_pkg::SPIKE_COUNT_WIDTH,
    parameter int CLAMP_NONNEG      = 1
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         StartValid,
    output logic                         StartReady,
    input  logic [NEURON_ID_WIDTH-1:0]   NeuronIDIn,
    input  logic signed [DATA_WIDTH-1:0] ginLeaked,
    input  logic [SPIKE_COUNT_WIDTH-1:0] SpikeCount,
    input  logic                         WeightValid,
    output logic                         WeightReady,
    input  logic signed [DATA_WIDTH-1:0] Weight,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [NEURON_ID_WIDTH-1:0]   NeuronIDOut,
    output logic signed [DATA_WIDTH-1:0] ginOut,
    output logic                         Saturated,
    output logic                         Busy
);
    localparam bit DO_CLAMP = (CLAMP_NONNEG != 0);

    gin_state_e state, state_nxt;

    logic signed [DATA_WIDTH-1:0]  acc;
    logic signed [DATA_WIDTH-1:0]  acc_sum;
    logic [NEURON_ID_WIDTH-1:0]    id;
    logic [SPIKE_COUNT_WIDTH-1:0]  cnt;
    logic                          sat;
    logic                          add_ovf;
    logic                          live;
    logic                          start_hs;
    logic                          weight_hs;
    logic                          clamp_hit;

    gin_sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_sat_add (
        .a        (acc),
        .b        (Weight),
        .sum      (acc_sum),
        .overflow (add_ovf)
    );

    // live holds StartReady low while reset is asserted and for the edge it releases on
    assign start_hs  = (state == IDLE) && live && StartValid;
    assign weight_hs = (state == ACCUM) && WeightValid;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_hs) begin
                    state_nxt = (SpikeCount == '0) ? OUTPUT : ACCUM;
                end
            end
            ACCUM: begin
                if (weight_hs && (cnt == SPIKE_COUNT_WIDTH'(1))) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (OutReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc  <= '0;
            id   <= '0;
            cnt  <= '0;
            sat  <= 1'b0;
            live <= 1'b0;
        end else begin
            live <= 1'b1;
            if (start_hs) begin
                acc <= ginLeaked;
                id  <= NeuronIDIn;
                cnt <= SpikeCount;
                sat <= 1'b0;
            end else if (weight_hs) begin
                acc <= acc_sum;
                cnt <= cnt - 1'b1;
                sat <= sat | add_ovf;
            end
        end
    end

    always_comb begin
        StartReady  = (state == IDLE) && live;
        WeightReady = (state == ACCUM);
        OutValid    = (state == OUTPUT);
        Busy        = (state != IDLE);
        clamp_hit   = DO_CLAMP && acc[DATA_WIDTH-1];
        ginOut      = '0;
        NeuronIDOut = '0;
        Saturated   = 1'b0;
        if (state == OUTPUT) begin
            ginOut      = clamp_hit ? '0 : acc;
            NeuronIDOut = id;
            Saturated   = sat | clamp_hit;
        end
    end
endmodule

// File: tb/tb_gin_synaptic_accumulator.sv
// Scoreboard bench: two instances (clamping and non-clamping) share stimulus;
// expected results are queued at issue time and checked by an output monitor.
`timescale 1ns/1ps
module tb_gin_synaptic_accumulator;
    import gin_pkg::*;

    typedef struct {
        logic [10:0] id;
        logic [63:0] gin;
        logic        sat;
    } exp_t;

    logic               Clock = 1'b0;
    logic               Reset;
    logic               StartValid;
    logic [10:0]        NeuronIDIn;
    logic signed [63:0] ginLeaked;
    logic [9:0]         SpikeCount;
    logic               WeightValid;
    logic signed [63:0] Weight;
    logic               OutReady;

    logic               sr1, wr1, ov1, s1, b1;
    logic [10:0]        id1;
    logic signed [63:0] g1;
    logic               sr0, wr0, ov0, s0, b0;
    logic [10:0]        id0;
    logic signed [63:0] g0;

    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   hs_count = 0;
    logic wr_seen = 1'b0;
    exp_t sb1[$];
    exp_t sb0[$];
    logic [63:0] wq[$];

    gin_synaptic_accumulator #(.CLAMP_NONNEG(1)) u_clamp (
        .Clock(Clock), .Reset(Reset), .StartValid(StartValid), .StartReady(sr1),
        .NeuronIDIn(NeuronIDIn), .ginLeaked(ginLeaked), .SpikeCount(SpikeCount),
        .WeightValid(WeightValid), .WeightReady(wr1), .Weight(Weight),
        .OutValid(ov1), .OutReady(OutReady), .NeuronIDOut(id1), .ginOut(g1),
        .Saturated(s1), .Busy(b1)
    );

    gin_synaptic_accumulator #(.CLAMP_NONNEG(0)) u_raw (
        .Clock(Clock), .Reset(Reset), .StartValid(StartValid), .StartReady(sr0),
        .NeuronIDIn(NeuronIDIn), .ginLeaked(ginLeaked), .SpikeCount(SpikeCount),
        .WeightValid(WeightValid), .WeightReady(wr0), .Weight(Weight),
        .OutValid(ov0), .OutReady(OutReady), .NeuronIDOut(id0), .ginOut(g0),
        .Saturated(s0), .Busy(b0)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    endtask

    // Output monitor: every handshake must match the oldest queued expectation
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset) begin
            if (wr1) wr_seen = 1'b1;
            if (ov1 && OutReady) begin
                hs_count++;
                if (sb1.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_out_clamp: got output id %0d, required none", id1);
                end else begin
                    e = sb1.pop_front();
                    check("clamp_gin", g1, e.gin);
                    check("clamp_id", 64'(id1), 64'(e.id));
                    check("clamp_sat", 64'(s1), 64'(e.sat));
                end
            end
            if (ov0 && OutReady) begin
                if (sb0.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_out_raw: got output id %0d, required none", id0);
                end else begin
                    e = sb0.pop_front();
                    check("raw_gin", g0, e.gin);
                    check("raw_id", 64'(id0), 64'(e.id));
                    check("raw_sat", 64'(s0), 64'(e.sat));
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_start(input logic [10:0] id, input logic [63:0] gl, input logic [9:0] n,
                            output int c);
        StartValid = 1'b1;
        NeuronIDIn = id;
        ginLeaked  = gl;
        SpikeCount = n;
        c = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clock);
            if (sr1) begin
                c = cyc;
                break;
            end
            tick();
        end
        if (c < 0) begin
            total++;
            $display("FAIL start_timeout: got StartReady low for 50 cycles, required high");
        end
        tick();
        // Scramble job inputs after the handshake; they must not be re-sampled
        StartValid = 1'b0;
        SpikeCount = 10'h3FF;
        ginLeaked  = '1;
        NeuronIDIn = '1;
    endtask

    task automatic do_weights(input int gap_max);
        int g;
        bit ok;
        while (wq.size() > 0) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            WeightValid = 1'b0;
            repeat (g) tick();
            WeightValid = 1'b1;
            Weight = wq.pop_front();
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge Clock);
                if (wr1) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            if (!ok) begin
                total++;
                $display("FAIL weight_timeout: got WeightReady low for 50 cycles, required high");
            end
            tick();
        end
        WeightValid = 1'b0;
        Weight = '0;
    endtask

    task automatic wait_out(output int t);
        t = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clock);
            if (ov1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            total++;
            $display("FAIL out_timeout: got OutValid low for 100 cycles, required high");
        end
    endtask

    task automatic run_job(input logic [10:0] id, input logic [63:0] gl, input int gap,
                           input int exp_lat, input logic [63:0] e1g, input logic e1s,
                           input logic [63:0] e0g, input logic e0s);
        int c, t, n;
        exp_t e;
        n = wq.size();
        e.id = id; e.gin = e1g; e.sat = e1s;
        sb1.push_back(e);
        e.gin = e0g; e.sat = e0s;
        sb0.push_back(e);
        do_start(id, gl, n[9:0], c);
        do_weights(gap);
        wait_out(t);
        if (exp_lat > 0) check("latency", 64'(t - c), 64'(exp_lat));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required $finish");
        $fatal(1);
    end

    initial begin
        int   c, t, h0, ov_cnt;
        exp_t e;
        Reset = 1'b1; StartValid = 1'b0; NeuronIDIn = '0; ginLeaked = '0;
        SpikeCount = '0; WeightValid = 1'b0; Weight = '0; OutReady = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_start_ready", 64'(sr1), 0);
        check("rst_weight_ready", 64'(wr1), 0);
        check("rst_out_valid", 64'(ov1), 0);
        check("rst_busy", 64'(b1), 0);
        check("rst_gin", g1, 0);
        check("rst_sat", 64'(s1), 0);
        Reset = 1'b0;
        tick();
        check("post_rst_start_ready", 64'(sr1), 1);

        // Reset mid-ACCUM after 2 of 5 weights: job vanishes
        do_start(11'd3, 64'h0000_0001_0000_0000, 10'd5, c);
        wq.push_back(64'h0000_0001_0000_0000);
        wq.push_back(64'h0000_0001_0000_0000);
        do_weights(0);
        check("t1_busy_before", 64'(b1), 1);
        #2 Reset = 1'b1;
        #1;
        check("t1_start_ready", 64'(sr1), 0);
        check("t1_weight_ready", 64'(wr1), 0);
        check("t1_out_valid", 64'(ov1), 0);
        check("t1_busy", 64'(b1), 0);
        check("t1_gin", g1, 0);
        check("t1_id", 64'(id1), 0);
        check("t1_sat", 64'(s1), 0);
        @(posedge Clock); #1 Reset = 1'b0;
        tick();
        check("t1_start_ready_after", 64'(sr1), 1);
        ov_cnt = 0;
        repeat (10) begin
            @(negedge Clock);
            if (ov1) ov_cnt++;
        end
        check("t1_no_output", 64'(ov_cnt), 0);
        tick();

        // 2.5 + 1.0 + 0.25 + 0.25 = 4.0, latency 4
        wq.push_back(64'h0000_0001_0000_0000);
        wq.push_back(64'h0000_0000_4000_0000);
        wq.push_back(64'h0000_0000_4000_0000);
        run_job(11'd7, 64'h0000_0002_8000_0000, 0, 4,
                64'h0000_0004_0000_0000, 1'b0, 64'h0000_0004_0000_0000, 1'b0);

        // Zero spikes: output one cycle after start, no weight phase
        wr_seen = 1'b0;
        run_job(11'd12, 64'h0000_0001_C000_0000, 0, 1,
                64'h0000_0001_C000_0000, 1'b0, 64'h0000_0001_C000_0000, 1'b0);
        check("t3_weight_ready_never", 64'(wr_seen), 0);

        // Positive overflow, then a clean job clears the sticky flag
        wq.push_back(64'h0000_0002_0000_0000);
        run_job(11'd8, 64'h7FFF_FFFF_0000_0000, 0, 2,
                GIN_MAX, 1'b1, GIN_MAX, 1'b1);
        wq.push_back(64'h0000_0001_0000_0000);
        run_job(11'd9, 64'h0000_0001_0000_0000, 0, 2,
                64'h0000_0002_0000_0000, 1'b0, 64'h0000_0002_0000_0000, 1'b0);

        // 0.5 - 1.0 = -0.5: clamped to 0 only on the clamping instance
        wq.push_back(64'hFFFF_FFFF_0000_0000);
        run_job(11'd10, 64'h0000_0000_8000_0000, 0, 2,
                64'h0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);

        // Per-beat saturation: +2.0 pins at max, -2.0 then subtracts from max
        wq.push_back(64'h0000_0002_0000_0000);
        wq.push_back(64'hFFFF_FFFE_0000_0000);
        run_job(11'd11, 64'h7FFF_FFFF_0000_0000, 0, 3,
                64'h7FFF_FFFD_FFFF_FFFF, 1'b1, 64'h7FFF_FFFD_FFFF_FFFF, 1'b1);

        // Negative overflow to min
        wq.push_back(64'hFFFF_FFFE_0000_0000);
        run_job(11'd2047, 64'h8000_0001_0000_0000, 0, 2,
                64'h0, 1'b1, GIN_MIN, 1'b1);

        // Backpressure with weight gaps: result held, no new start, one handshake
        OutReady = 1'b0;
        repeat (3) wq.push_back(64'h0000_0000_8000_0000);
        e.id = 11'd100; e.gin = 64'h0000_0002_8000_0000; e.sat = 1'b0;
        sb1.push_back(e);
        sb0.push_back(e);
        do_start(11'd100, 64'h0000_0001_0000_0000, 10'd3, c);
        do_weights(3);
        wait_out(t);
        h0 = hs_count;
        for (int i = 0; i < 10; i++) begin
            check("t6_hold_gin", g1, 64'h0000_0002_8000_0000);
            check("t6_hold_id", 64'(id1), 64'd100);
            check("t6_hold_start_ready", 64'(sr1), 0);
            @(negedge Clock);
        end
        @(posedge Clock); #1 OutReady = 1'b1;
        tick();
        @(negedge Clock);
        check("t6_one_handshake", 64'(hs_count - h0), 1);
        check("t6_start_ready_back", 64'(sr1), 1);
        repeat (3) @(negedge Clock);
        check("t6_still_one_handshake", 64'(hs_count - h0), 1);

        check("sb_clamp_empty", 64'(sb1.size()), 0);
        check("sb_raw_empty", 64'(sb0.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
